pcie_req_tlp_buffer: RTL and testbench

PCIE_REQ_TLP_BUFFER -- requirements
Module: pcie_req_tlp_buffer

---
 rtl/pcie_req_tlp_buffer.sv | 127 ++++++++++++
 tb/tb_pcie_req_tlp_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pcie_req_tlp_buffer.sv
// pcie_req_tlp_buffer: store-and-forward FIFO for inbound request TLPs.
// Beats are framed by a small IDLE/IN_PKT FSM. A beat that arrives outside a
// packet without sop is dropped and counted. The output is released only once
// a complete packet (eop) sits in the FIFO. If the FIFO fills up with no eop
// stored, the buffer falls back to cut-through so that packets longer than
// DEPTH cannot deadlock.
module pcie_req_tlp_buffer #(
  parameter int DATA_WIDTH = 256,
  parameter int HDR_WIDTH  = 128,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    s_tlp_data,
  input  logic [HDR_WIDTH-1:0]     s_tlp_hdr,
  input  logic                     s_tlp_valid,
  input  logic                     s_tlp_sop,
  input  logic                     s_tlp_eop,
  output logic                     s_tlp_ready,
  output logic [DATA_WIDTH-1:0]    rx_req_tlp_data,
  output logic [HDR_WIDTH-1:0]     rx_req_tlp_hdr,
  output logic                     rx_req_tlp_valid,
  output logic                     rx_req_tlp_sop,
  output logic                     rx_req_tlp_eop,
  input  logic                     rx_req_tlp_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     status_error_framing,
  output logic [15:0]              drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = DATA_WIDTH + HDR_WIDTH + 2;
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  typedef enum logic {IDLE, IN_PKT} state_t;

  // Entry layout: {data, hdr, sop, eop}
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   pkt_count;
  logic          cut_thru;
  state_t        state;

  logic          acc, wr_en, rd_en, wr_eop, rd_eop;
  logic [W-1:0]  head;

  assign head   = mem[rd_ptr];
  assign acc    = s_tlp_valid && s_tlp_ready;
  // Outside a packet only a sop beat may start one; everything else is dropped.
  assign wr_en  = acc && (state == IN_PKT || s_tlp_sop);
  assign rd_en  = rx_req_tlp_valid && rx_req_tlp_ready;
  assign wr_eop = wr_en && s_tlp_eop;
  assign rd_eop = rd_en && head[0];

  // Ready depends only on occupancy; no pass-through when full.
  assign s_tlp_ready = (fill_level < FULL);

  // cut_thru keeps a full-FIFO fallback draining after the first beat leaves,
  // until the oversized packet's eop is read or the FIFO runs dry.
  assign rx_req_tlp_valid = (fill_level != '0) &&
                            (pkt_count != '0 || fill_level == FULL || cut_thru);
  assign rx_req_tlp_data  = head[W-1 -: DATA_WIDTH];
  assign rx_req_tlp_hdr   = head[2 +: HDR_WIDTH];
  assign rx_req_tlp_sop   = rx_req_tlp_valid && head[1];
  assign rx_req_tlp_eop   = rx_req_tlp_valid && head[0];

  // Storage array; contents need no reset because pointers and occupancy qualify them.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {s_tlp_data, s_tlp_hdr, s_tlp_sop, s_tlp_eop};
  end

  // Pointers, occupancy, complete-packet count and cut-through latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      pkt_count  <= '0;
      cut_thru   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   fill_level <= fill_level + (AW+1)'(1);
        2'b01:   fill_level <= fill_level - (AW+1)'(1);
        default: fill_level <= fill_level;
      endcase
      case ({wr_eop, rd_eop})
        2'b10:   pkt_count <= pkt_count + (AW+1)'(1);
        2'b01:   pkt_count <= pkt_count - (AW+1)'(1);
        default: pkt_count <= pkt_count;
      endcase
      if (rd_eop || (rd_en && !wr_en && fill_level == (AW+1)'(1)))
        cut_thru <= 1'b0;
      else if (fill_level == FULL && pkt_count == '0)
        cut_thru <= 1'b1;
    end
  end

  // Input framing FSM with registered error pulse and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      status_error_framing <= 1'b0;
      drop_count           <= '0;
    end else begin
      status_error_framing <= 1'b0;
      if (acc) begin
        case (state)
          IDLE: begin
            if (!s_tlp_sop) begin
              status_error_framing <= 1'b1;
              if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end else if (!s_tlp_eop) begin
              state <= IN_PKT;
            end
          end
          IN_PKT: begin
            // A sop here restarts framing; the beat is kept, only flagged.
            if (s_tlp_sop) status_error_framing <= 1'b1;
            if (s_tlp_eop) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pcie_req_tlp_buffer.sv
// Directed bench for pcie_req_tlp_buffer: vector table plus hand sequences
// for the full-FIFO and mid-operation reset cases.
module tb_pcie_req_tlp_buffer;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] s_tlp_data;
  logic [127:0] s_tlp_hdr;
  logic         s_tlp_valid, s_tlp_sop, s_tlp_eop;
  logic         s_tlp_ready;
  logic [255:0] rx_req_tlp_data;
  logic [127:0] rx_req_tlp_hdr;
  logic         rx_req_tlp_valid, rx_req_tlp_sop, rx_req_tlp_eop;
  logic         rx_req_tlp_ready;
  logic [4:0]   fill_level;
  logic         status_error_framing;
  logic [15:0]  drop_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pcie_req_tlp_buffer #(.DATA_WIDTH(256), .HDR_WIDTH(128), .DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .s_tlp_data(s_tlp_data), .s_tlp_hdr(s_tlp_hdr), .s_tlp_valid(s_tlp_valid),
    .s_tlp_sop(s_tlp_sop), .s_tlp_eop(s_tlp_eop), .s_tlp_ready(s_tlp_ready),
    .rx_req_tlp_data(rx_req_tlp_data), .rx_req_tlp_hdr(rx_req_tlp_hdr),
    .rx_req_tlp_valid(rx_req_tlp_valid), .rx_req_tlp_sop(rx_req_tlp_sop),
    .rx_req_tlp_eop(rx_req_tlp_eop), .rx_req_tlp_ready(rx_req_tlp_ready),
    .fill_level(fill_level), .status_error_framing(status_error_framing),
    .drop_count(drop_count)
  );

  typedef struct {
    logic         v, sop, eop, rdy;
    logic [127:0] hdr;
    logic [255:0] data;
    logic         e_srdy, e_vld, e_sop, e_eop, e_err;
    logic [4:0]   e_fill;
    logic [15:0]  e_drop;
    logic [127:0] e_hdr;
    logic [255:0] e_data;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [255:0] dat(input int i);
    logic [31:0] w;
    w = 32'hA5A5_0000 ^ i;
    return {8{w}};
  endfunction

  function automatic logic [127:0] hd(input int i);
    logic [31:0] w;
    w = 32'h4A00_0000 | i;
    return {w, 32'h0, 32'h1122_3344, 32'h5566_7788};
  endfunction

  function automatic vec_t mkv(input logic v, sop, eop, rdy, input int di,
                               input logic e_vld, e_sop, e_eop, e_err,
                               input int e_fill, input int e_drop, input int e_di);
    vec_t r;
    r.v = v; r.sop = sop; r.eop = eop; r.rdy = rdy;
    r.hdr = hd(di); r.data = dat(di);
    r.e_srdy = 1'b1; r.e_vld = e_vld; r.e_sop = e_sop; r.e_eop = e_eop;
    r.e_err = e_err; r.e_fill = e_fill[4:0]; r.e_drop = e_drop[15:0];
    r.e_hdr = hd(e_di); r.e_data = dat(e_di);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic v, sop, eop, rdy, input int di);
    s_tlp_valid = v; s_tlp_sop = sop; s_tlp_eop = eop;
    s_tlp_data = dat(di); s_tlp_hdr = hd(di); rx_req_tlp_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares the full observable state; payload only when a beat is presented.
  task automatic chk_all(input string nm, input logic srdy, vld, sop, eop, err,
                         input int fill, input int drop, input int di);
    chk({nm, ".s_ready"}, 256'(s_tlp_ready), 256'(srdy));
    chk({nm, ".valid"}, 256'(rx_req_tlp_valid), 256'(vld));
    chk({nm, ".sop"}, 256'(rx_req_tlp_sop), 256'(sop));
    chk({nm, ".eop"}, 256'(rx_req_tlp_eop), 256'(eop));
    chk({nm, ".err"}, 256'(status_error_framing), 256'(err));
    chk({nm, ".fill"}, 256'(fill_level), 256'(fill[4:0]));
    chk({nm, ".drop"}, 256'(drop_count), 256'(drop[15:0]));
    if (vld) begin
      chk({nm, ".data"}, rx_req_tlp_data, dat(di));
      chk({nm, ".hdr"}, 256'(rx_req_tlp_hdr), 256'(hd(di)));
    end
  endtask

  initial begin
    // v  sop eop rdy  d | vld sop eop err fill drop e_d
    vecs[0]  = mkv(1,1,1,1, 1,  1,1,1,0, 1,0, 1);   // single-beat TLP, out next cycle
    vecs[1]  = mkv(0,0,0,1, 0,  0,0,0,0, 0,0, 0);
    vecs[2]  = mkv(1,1,0,1, 2,  0,0,0,0, 1,0, 0);   // 4-beat TLP held until eop
    vecs[3]  = mkv(1,0,0,1, 3,  0,0,0,0, 2,0, 0);
    vecs[4]  = mkv(1,0,0,1, 4,  0,0,0,0, 3,0, 0);
    vecs[5]  = mkv(1,0,1,1, 5,  1,1,0,0, 4,0, 2);
    vecs[6]  = mkv(0,0,0,1, 0,  1,0,0,0, 3,0, 3);
    vecs[7]  = mkv(0,0,0,1, 0,  1,0,0,0, 2,0, 4);
    vecs[8]  = mkv(0,0,0,1, 0,  1,0,1,0, 1,0, 5);
    vecs[9]  = mkv(0,0,0,1, 0,  0,0,0,0, 0,0, 0);
    vecs[10] = mkv(1,0,0,1, 9,  0,0,0,1, 0,1, 0);   // no sop in IDLE: dropped
    vecs[11] = mkv(0,0,0,1, 0,  0,0,0,0, 0,1, 0);
    vecs[12] = mkv(1,1,0,1, 6,  0,0,0,0, 1,1, 0);
    vecs[13] = mkv(1,1,1,1, 7,  1,1,0,1, 2,1, 6);   // sop mid-packet: kept, flagged
    vecs[14] = mkv(0,0,0,1, 0,  1,1,1,0, 1,1, 7);
    vecs[15] = mkv(0,0,0,1, 0,  0,0,0,0, 0,1, 0);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    chk_all("reset", 1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].v, vecs[i].sop, vecs[i].eop, vecs[i].rdy, 0);
      s_tlp_data = vecs[i].data; s_tlp_hdr = vecs[i].hdr;
      tick();
      chk($sformatf("vec%0d.s_ready", i), 256'(s_tlp_ready), 256'(vecs[i].e_srdy));
      chk($sformatf("vec%0d.valid", i), 256'(rx_req_tlp_valid), 256'(vecs[i].e_vld));
      chk($sformatf("vec%0d.sop", i), 256'(rx_req_tlp_sop), 256'(vecs[i].e_sop));
      chk($sformatf("vec%0d.eop", i), 256'(rx_req_tlp_eop), 256'(vecs[i].e_eop));
      chk($sformatf("vec%0d.err", i), 256'(status_error_framing), 256'(vecs[i].e_err));
      chk($sformatf("vec%0d.fill", i), 256'(fill_level), 256'(vecs[i].e_fill));
      chk($sformatf("vec%0d.drop", i), 256'(drop_count), 256'(vecs[i].e_drop));
      if (vecs[i].e_vld) begin
        chk($sformatf("vec%0d.data", i), rx_req_tlp_data, vecs[i].e_data);
        chk($sformatf("vec%0d.hdr", i), 256'(rx_req_tlp_hdr), 256'(vecs[i].e_hdr));
      end
    end

    // Fill with 16 beats of an unterminated packet while the sink stalls.
    for (int i = 0; i < 16; i++) begin
      drive(1, i == 0, 0, 0, 100 + i);
      tick();
      if (i == 14) chk_all("fill15", 1, 0, 0, 0, 0, 15, 1, 0);
    end
    chk_all("full_cut", 0, 1, 1, 0, 0, 16, 1, 100);
    // Read while full with input pending: input must wait a cycle.
    drive(1, 0, 1, 1, 200);
    tick();
    chk_all("full_rw", 1, 1, 0, 0, 0, 15, 1, 101);
    drive(1, 0, 1, 0, 200);
    tick();
    chk_all("late_acc", 0, 1, 0, 0, 0, 16, 1, 101);
    // Drain everything in order; the eop beat comes last.
    drive(0, 0, 0, 1, 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i < 15)
        chk_all($sformatf("drain%0d", i), 1, 1, 0, 0, 0, 16 - i, 1, 101 + i);
      else if (i == 15)
        chk_all("drain15", 1, 1, 0, 1, 0, 1, 1, 200);
      else
        chk_all("drain16", 1, 0, 0, 0, 0, 0, 1, 0);
    end

    // Reset with a partial packet stored.
    for (int i = 0; i < 3; i++) begin
      drive(1, i == 0, 0, 0, 300 + i);
      tick();
    end
    chk_all("pre_rst", 1, 0, 0, 0, 0, 3, 1, 0);
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("mid_rst", 1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 1, 400);
    tick();
    chk_all("post_rst", 1, 1, 1, 1, 0, 1, 0, 400);
    drive(0, 0, 0, 1, 0);
    tick();
    chk_all("post_rst_rd", 1, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
